bus_master_seq: RTL

BUS_MASTER_SEQ -- requirements
Module: bus_master_seq

---
 rtl/bus_master_seq.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/bus_master_seq.sv
`default_nettype none
// ============================================================================
// Module   : bus_master_seq
// Purpose  : Command FIFO feeding a single-outstanding bus master with
//            address/data phases, per-phase timeout and a held response.
// Revision : 1.0 - initial release
// ============================================================================
module bus_master_seq #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDR_W-1:0]      cmd_addr,
  input  logic [DATA_W-1:0]      cmd_wdata,
  output logic [$clog2(DEPTH):0] cmd_level,
  output logic                   bus_valid,
  output logic                   bus_write,
  output logic                   bus_read,
  output logic [ADDR_W-1:0]      bus_addr,
  output logic [DATA_W-1:0]      bus_write_data,
  input  logic                   bus_ready,
  input  logic [DATA_W-1:0]      bus_read_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_write,
  output logic                   rsp_err
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int c_ENT_W = 1 + ADDR_W + DATA_W;
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
  localparam logic [c_PTR_W:0]   c_LVL_ONE = (c_PTR_W + 1)'(1);
  localparam logic [c_PTR_W:0]   c_DEPTH   = (c_PTR_W + 1)'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_ENT_W-1:0]  r_mem [DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_PTR_W:0]    r_count;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_act_write;
  logic [ADDR_W-1:0]   r_act_addr;
  logic [DATA_W-1:0]   r_act_wdata;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic                w_push;
  logic                w_pop;
  logic                w_in_phase;
  logic                w_timeout;

  assign cmd_ready  = (r_count != c_DEPTH);
  assign cmd_level  = r_count;
  assign w_push     = cmd_valid && cmd_ready;
  assign w_pop      = (r_state == IDLE) && (r_count != '0);
  assign w_in_phase = (r_state == ADDR) || (r_state == DATA);
  // A completing slave in the same cycle takes priority over the timeout.
  assign w_timeout  = (TIMEOUT > 0) && w_in_phase && !bus_ready && (r_cnt == c_TIMEOUT);

  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_write = r_act_write;
  assign rsp_err   = r_rsp_err;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    bus_valid      = 1'b0;
    bus_write      = 1'b0;
    bus_read       = 1'b0;
    bus_addr       = '0;
    bus_write_data = '0;
    case (r_state)
      IDLE: begin
        if (w_pop) w_state_nxt = ADDR;
      end
      ADDR, DATA: begin
        bus_valid = 1'b1;
        bus_write = r_act_write;
        bus_read  = !r_act_write;
        bus_addr  = r_act_addr;
        if (r_state == DATA && r_act_write) bus_write_data = r_act_wdata;
        if (bus_ready)      w_state_nxt = (r_state == ADDR) ? DATA : RESP;
        else if (w_timeout) w_state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_cnt       <= '0;
      r_act_write <= 1'b0;
      r_act_addr  <= '0;
      r_act_wdata <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        {r_act_write, r_act_addr, r_act_wdata} <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_LVL_ONE;
        2'b01:   r_count <= r_count - c_LVL_ONE;
        default: r_count <= r_count;
      endcase
      // Any state change restarts the phase counter, covering ADDR and DATA entry.
      if (w_state_nxt != r_state)          r_cnt <= '0;
      else if (w_in_phase && !bus_ready)   r_cnt <= r_cnt + c_CNT_ONE;
      if (w_state_nxt == RESP && r_state != RESP) begin
        r_rsp_err   <= w_timeout;
        r_rsp_rdata <= (w_timeout || r_act_write) ? '0 : bus_read_data;
      end
    end
  end

endmodule
`default_nettype wire
